spi_slave_fsm: RTL and testbench

Transaction controller for the SPI slave datapath. It consumes conditioned chip-select and SCLK edge pulses and drives the mode input of the 8-bit shift register. It watches the register's parallel output to capture the address/RW byte and sequences the read (parallel-load then shift-out) or write (shift-in then commit) phase. It sits between the input conditioners and the shift register / data memory.

---
 rtl/spi_slave_fsm_pkg.sv | 32 +++
 rtl/spi_slave_fsm_if.sv | 27 ++
 rtl/spi_bit_counter.sv | 37 +++
 rtl/spi_slave_fsm.sv | 171 +++++++++++++++++
 tb/tb_spi_slave_fsm.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/spi_slave_fsm_pkg.sv
// Shared definitions for the SPI slave datapath: shift-register mode codes
// (also used by the shift register itself) and the transaction FSM states.
package spi_slave_fsm_pkg;

    localparam logic [1:0] SR_HOLD  = 2'b00;
    localparam logic [1:0] SR_RIGHT = 2'b01;
    localparam logic [1:0] SR_LEFT  = 2'b10;
    localparam logic [1:0] SR_PLOAD = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE         = 3'd0,
        ST_GET_ADDR     = 3'd1,
        ST_GOT_ADDR     = 3'd2,
        ST_READ_LOAD    = 3'd3,
        ST_READ         = 3'd4,
        ST_WRITE        = 3'd5,
        ST_WRITE_COMMIT = 3'd6,
        ST_DONE         = 3'd7
    } spi_state_e;

    // States in which a chip-select release leaves a transaction unfinished.
    function automatic logic is_abort_state(input spi_state_e st);
        logic hit_s;
        case (st)
            ST_GET_ADDR, ST_READ_LOAD, ST_READ,
            ST_WRITE, ST_WRITE_COMMIT: hit_s = 1'b1;
            default:                   hit_s = 1'b0;
        endcase
        return hit_s;
    endfunction

endpackage

// File: rtl/spi_slave_fsm_if.sv
// Bus bundle between the SPI input conditioners / shift register and the
// transaction FSM. The FSM side uses the slave modport.
interface spi_slave_fsm_if #(parameter int width = 8);

    logic             cs_n;
    logic             sclk_pos;
    logic             sclk_neg;
    logic [width-1:0] sr_q;
    logic [1:0]       sr_mode;
    logic [width-2:0] addr;
    logic             addr_we;
    logic             dm_we;
    logic             miso_en;
    logic             busy;
    logic             abort_err;

    modport slave (
        input  cs_n, sclk_pos, sclk_neg, sr_q,
        output sr_mode, addr, addr_we, dm_we, miso_en, busy, abort_err
    );

    modport master (
        output cs_n, sclk_pos, sclk_neg, sr_q,
        input  sr_mode, addr, addr_we, dm_we, miso_en, busy, abort_err
    );

endinterface

// File: rtl/spi_bit_counter.sv
// Saturating bit counter for the SPI slave FSM: counts qualified SCLK edges
// up to width and stops there; clear has priority over enable.
module spi_bit_counter #(
    parameter int width = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic done,
    output logic last
);

    localparam int CW = $clog2(width) + 1;
    localparam logic [CW-1:0] CNT_MAX  = CW'(width);
    localparam logic [CW-1:0] CNT_LAST = CW'(width - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [CW-1:0] cnt_r;

    // Edge counter register: clear, saturating increment, or hold.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r <= {CW{1'b0}};
        end else if (clr) begin
            cnt_r <= {CW{1'b0}};
        end else if (en && (cnt_r != CNT_MAX)) begin
            cnt_r <= cnt_r + CNT_ONE;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign done = (cnt_r == CNT_MAX);
    assign last = (cnt_r == CNT_LAST);

endmodule

// File: rtl/spi_slave_fsm.sv
// SPI slave transaction controller: address/RW capture, then read (load +
// shift out) or write (shift in + commit). Optional sticky abort flag is
// built when SPI_FSM_ABORT_ERR_EN is defined.
module spi_slave_fsm
    import spi_slave_fsm_pkg::*;
#(
    parameter int width = 8
) (
    input  logic           clk,
    input  logic           reset,
    spi_slave_fsm_if.slave bus
);

    spi_state_e       state_r;
    spi_state_e       state_next_s;
    logic [1:0]       sr_mode_s;
    logic             addr_we_s;
    logic             dm_we_s;
    logic             cnt_en_s;
    logic             cnt_clr_s;
    logic             cnt_done_s;
    logic             cnt_last_s;
    logic [width-2:0] addr_r;

    spi_bit_counter #(.width(width)) u_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr_s),
        .en    (cnt_en_s),
        .done  (cnt_done_s),
        .last  (cnt_last_s)
    );

    // The counter restarts on every state change and is held clear in IDLE.
    assign cnt_clr_s = (state_next_s != state_r) || (state_r == ST_IDLE);

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next state and Mealy outputs; a released chip select overrides everything.
    always_comb begin
        state_next_s = state_r;
        sr_mode_s    = SR_HOLD;
        addr_we_s    = 1'b0;
        dm_we_s      = 1'b0;
        cnt_en_s     = 1'b0;
        if ((state_r != ST_IDLE) && bus.cs_n) begin
            state_next_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (!bus.cs_n) begin
                        state_next_s = ST_GET_ADDR;
                    end else begin
                        state_next_s = ST_IDLE;
                    end
                end
                ST_GET_ADDR: begin
                    if (bus.sclk_pos && !cnt_done_s) begin
                        sr_mode_s = SR_LEFT;
                        cnt_en_s  = 1'b1;
                        if (cnt_last_s) begin
                            state_next_s = ST_GOT_ADDR;
                        end else begin
                            state_next_s = ST_GET_ADDR;
                        end
                    end else if (cnt_done_s) begin
                        state_next_s = ST_GOT_ADDR;
                    end else begin
                        state_next_s = ST_GET_ADDR;
                    end
                end
                ST_GOT_ADDR: begin
                    addr_we_s    = 1'b1;
                    state_next_s = bus.sr_q[0] ? ST_READ_LOAD : ST_WRITE;
                end
                ST_READ_LOAD: begin
                    sr_mode_s    = SR_PLOAD;
                    state_next_s = ST_READ;
                end
                ST_READ: begin
                    // Read data leaves on falling SCLK so the master samples it on the rising edge.
                    if (bus.sclk_neg && !cnt_done_s) begin
                        sr_mode_s = SR_LEFT;
                        cnt_en_s  = 1'b1;
                        if (cnt_last_s) begin
                            state_next_s = ST_DONE;
                        end else begin
                            state_next_s = ST_READ;
                        end
                    end else if (cnt_done_s) begin
                        state_next_s = ST_DONE;
                    end else begin
                        state_next_s = ST_READ;
                    end
                end
                ST_WRITE: begin
                    if (bus.sclk_pos && !cnt_done_s) begin
                        sr_mode_s = SR_LEFT;
                        cnt_en_s  = 1'b1;
                        if (cnt_last_s) begin
                            state_next_s = ST_WRITE_COMMIT;
                        end else begin
                            state_next_s = ST_WRITE;
                        end
                    end else if (cnt_done_s) begin
                        state_next_s = ST_WRITE_COMMIT;
                    end else begin
                        state_next_s = ST_WRITE;
                    end
                end
                ST_WRITE_COMMIT: begin
                    dm_we_s      = 1'b1;
                    state_next_s = ST_DONE;
                end
                ST_DONE: begin
                    state_next_s = ST_DONE;
                end
                default: begin
                    state_next_s = ST_IDLE;
                end
            endcase
        end
    end

    // Address latch, loaded from the upper bits of the first byte.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_r <= {(width-1){1'b0}};
        end else if (addr_we_s) begin
            addr_r <= bus.sr_q[width-1:1];
        end else begin
            addr_r <= addr_r;
        end
    end

`ifdef SPI_FSM_ABORT_ERR_EN
    logic abort_err_r;

    // Sticky abort flag, cleared when the next transaction starts.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            abort_err_r <= 1'b0;
        end else if (bus.cs_n && is_abort_state(state_r)) begin
            abort_err_r <= 1'b1;
        end else if ((state_r == ST_IDLE) && !bus.cs_n) begin
            abort_err_r <= 1'b0;
        end else begin
            abort_err_r <= abort_err_r;
        end
    end

    assign bus.abort_err = abort_err_r;
`else
    assign bus.abort_err = 1'b0;
`endif

    assign bus.sr_mode = sr_mode_s;
    assign bus.addr    = addr_r;
    assign bus.addr_we = addr_we_s;
    assign bus.dm_we   = dm_we_s;
    assign bus.miso_en = (state_r == ST_READ);
    assign bus.busy    = (state_r != ST_IDLE);

endmodule

// File: tb/tb_spi_slave_fsm.sv
// Directed bench for spi_slave_fsm: a per-cycle vector table for full write
// and read transactions, then hand sequences for abort and mid-read reset.
module tb_spi_slave_fsm;
    import spi_slave_fsm_pkg::*;

    typedef struct {
        logic       cs_n;
        logic       pos;
        logic       neg;
        logic       mosi;
        logic [1:0] mode;
        logic       awe;
        logic       dwe;
        logic       men;
        logic       busy;
        logic [6:0] addr;
        logic       chk_sr;
        logic [7:0] sr;
    } vec_t;

`ifdef SPI_FSM_ABORT_ERR_EN
    localparam logic ABORT_EXP = 1'b1;
`else
    localparam logic ABORT_EXP = 1'b0;
`endif
    localparam logic [7:0] MEM_DATA = 8'h5A;

    logic       clk = 1'b0;
    logic       reset;
    logic       mosi;
    logic [7:0] sr_model;
    int         checks = 0;
    int         errors = 0;
    int         dm_cnt = 0;

    always #5 clk = ~clk;

    spi_slave_fsm_if #(.width(8)) bus ();

    spi_slave_fsm #(.width(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Shift-register model driven by the DUT's mode output.
    always @(posedge clk or posedge reset) begin
        if (reset) sr_model <= 8'h00;
        else begin
            case (bus.sr_mode)
                SR_LEFT:  sr_model <= {sr_model[6:0], mosi};
                SR_RIGHT: sr_model <= {mosi, sr_model[7:1]};
                SR_PLOAD: sr_model <= MEM_DATA;
                default:  sr_model <= sr_model;
            endcase
        end
    end
    assign bus.sr_q = sr_model;

    always @(negedge clk) if (bus.dm_we === 1'b1) dm_cnt++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic c, input logic p, input logic n, input logic m);
        @(posedge clk);
        #1;
        bus.cs_n = c; bus.sclk_pos = p; bus.sclk_neg = n; mosi = m;
        @(negedge clk);
    endtask

    task automatic shift_bits(input logic [7:0] b, input int nb, input logic use_neg, input string tag);
        for (int i = 0; i < nb; i++) begin
            cyc(1'b0, !use_neg, use_neg, b[7-i]);
            chk($sformatf("%s bit%0d mode", tag, i), bus.sr_mode, SR_LEFT);
        end
    endtask

    function automatic vec_t mk(input logic c, input logic p, input logic n, input logic m,
                                input logic [1:0] md, input logic aw, input logic dw,
                                input logic me, input logic bz, input logic [6:0] ad,
                                input logic cs, input logic [7:0] s);
        vec_t v;
        v.cs_n = c; v.pos = p; v.neg = n; v.mosi = m; v.mode = md; v.awe = aw;
        v.dwe = dw; v.men = me; v.busy = bz; v.addr = ad; v.chk_sr = cs; v.sr = s;
        return v;
    endfunction

    initial begin
        vec_t       tbl[$];
        logic [7:0] bb;

        // Write transaction: address 0x2A, data 0xC3, then extra pulses in DONE.
        tbl.push_back(mk(1, 0, 0, 0, SR_HOLD, 0, 0, 0, 0, 7'h00, 0, 8'h00));
        tbl.push_back(mk(0, 0, 0, 0, SR_HOLD, 0, 0, 0, 0, 7'h00, 0, 8'h00));
        tbl.push_back(mk(0, 0, 0, 0, SR_HOLD, 0, 0, 0, 1, 7'h00, 0, 8'h00));
        tbl.push_back(mk(0, 0, 1, 1, SR_HOLD, 0, 0, 0, 1, 7'h00, 0, 8'h00));
        bb = 8'h2A;
        for (int i = 0; i < 8; i++)
            tbl.push_back(mk(0, 1, 0, bb[7-i], SR_LEFT, 0, 0, 0, 1, 7'h00, 0, 8'h00));
        tbl.push_back(mk(0, 0, 0, 0, SR_HOLD, 1, 0, 0, 1, 7'h00, 1, 8'h2A));
        bb = 8'hC3;
        for (int i = 0; i < 8; i++)
            tbl.push_back(mk(0, 1, (i == 2), bb[7-i], SR_LEFT, 0, 0, 0, 1, 7'h15, 0, 8'h00));
        tbl.push_back(mk(0, 0, 0, 0, SR_HOLD, 0, 1, 0, 1, 7'h15, 1, 8'hC3));
        tbl.push_back(mk(0, 1, 1, 1, SR_HOLD, 0, 0, 0, 1, 7'h15, 1, 8'hC3));
        tbl.push_back(mk(0, 0, 1, 0, SR_HOLD, 0, 0, 0, 1, 7'h15, 0, 8'h00));
        tbl.push_back(mk(0, 1, 0, 0, SR_HOLD, 0, 0, 0, 1, 7'h15, 1, 8'hC3));
        tbl.push_back(mk(1, 0, 0, 0, SR_HOLD, 0, 0, 0, 1, 7'h15, 0, 8'h00));
        tbl.push_back(mk(1, 0, 0, 0, SR_HOLD, 0, 0, 0, 0, 7'h15, 0, 8'h00));
        // Read transaction: address 0x2B, memory byte 0x5A shifted out on sclk_neg.
        tbl.push_back(mk(0, 0, 0, 0, SR_HOLD, 0, 0, 0, 0, 7'h15, 0, 8'h00));
        bb = 8'h2B;
        for (int i = 0; i < 8; i++)
            tbl.push_back(mk(0, 1, 0, bb[7-i], SR_LEFT, 0, 0, 0, 1, 7'h15, 0, 8'h00));
        tbl.push_back(mk(0, 0, 0, 0, SR_HOLD,  1, 0, 0, 1, 7'h15, 1, 8'h2B));
        tbl.push_back(mk(0, 0, 0, 0, SR_PLOAD, 0, 0, 0, 1, 7'h15, 0, 8'h00));
        tbl.push_back(mk(0, 0, 0, 0, SR_HOLD,  0, 0, 1, 1, 7'h15, 1, 8'h5A));
        tbl.push_back(mk(0, 1, 0, 0, SR_HOLD,  0, 0, 1, 1, 7'h15, 1, 8'h5A));
        for (int i = 0; i < 8; i++)
            tbl.push_back(mk(0, (i == 1), 1, 0, SR_LEFT, 0, 0, 1, 1, 7'h15, 0, 8'h00));
        tbl.push_back(mk(0, 0, 1, 0, SR_HOLD, 0, 0, 0, 1, 7'h15, 1, 8'h00));
        tbl.push_back(mk(1, 0, 0, 0, SR_HOLD, 0, 0, 0, 1, 7'h15, 0, 8'h00));
        tbl.push_back(mk(1, 0, 0, 0, SR_HOLD, 0, 0, 0, 0, 7'h15, 0, 8'h00));

        reset = 1'b1; bus.cs_n = 1'b1; bus.sclk_pos = 1'b0; bus.sclk_neg = 1'b0; mosi = 1'b0;
        #12;
        chk("reset sr_mode", bus.sr_mode, SR_HOLD);
        chk("reset addr", bus.addr, 7'h00);
        chk("reset busy", bus.busy, 1'b0);
        chk("reset strobes", {bus.addr_we, bus.dm_we, bus.miso_en, bus.abort_err}, 4'h0);
        @(posedge clk);
        #1 reset = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            cyc(tbl[i].cs_n, tbl[i].pos, tbl[i].neg, tbl[i].mosi);
            chk($sformatf("row%0d sr_mode", i), bus.sr_mode, tbl[i].mode);
            chk($sformatf("row%0d addr_we", i), bus.addr_we, tbl[i].awe);
            chk($sformatf("row%0d dm_we", i), bus.dm_we, tbl[i].dwe);
            chk($sformatf("row%0d miso_en", i), bus.miso_en, tbl[i].men);
            chk($sformatf("row%0d busy", i), bus.busy, tbl[i].busy);
            chk($sformatf("row%0d addr", i), bus.addr, tbl[i].addr);
            chk($sformatf("row%0d abort_err", i), bus.abort_err, 1'b0);
            if (tbl[i].chk_sr) chk($sformatf("row%0d sr_q", i), bus.sr_q, tbl[i].sr);
        end
        chk("table dm_we count", dm_cnt, 1);

        // Abort after five write data bits.
        cyc(0, 0, 0, 0);
        shift_bits(8'h2A, 8, 1'b0, "abort addr");
        cyc(0, 0, 0, 0);
        chk("abort addr_we", bus.addr_we, 1'b1);
        shift_bits(8'hC3, 5, 1'b0, "abort data");
        cyc(1, 0, 0, 0);
        chk("abort cycle dm_we", bus.dm_we, 1'b0);
        chk("abort cycle sr_mode", bus.sr_mode, SR_HOLD);
        chk("abort cycle busy", bus.busy, 1'b1);
        cyc(1, 0, 0, 0);
        chk("after abort busy", bus.busy, 1'b0);
        chk("after abort abort_err", bus.abort_err, ABORT_EXP);
        chk("abort dm_we count", dm_cnt, 1);
        cyc(0, 0, 0, 0);
        chk("restart idle abort_err", bus.abort_err, ABORT_EXP);
        cyc(0, 0, 0, 0);
        chk("restart get_addr busy", bus.busy, 1'b1);
        chk("restart abort_err cleared", bus.abort_err, 1'b0);

        // Read interrupted by an asynchronous reset.
        shift_bits(8'h2B, 8, 1'b0, "rst addr");
        cyc(0, 0, 0, 0);
        chk("rst addr_we", bus.addr_we, 1'b1);
        cyc(0, 0, 0, 0);
        chk("rst pload", bus.sr_mode, SR_PLOAD);
        shift_bits(8'h00, 3, 1'b1, "rst read");
        chk("rst read miso_en", bus.miso_en, 1'b1);
        #1 reset = 1'b1;
        #1;
        chk("mid-read reset sr_mode", bus.sr_mode, SR_HOLD);
        chk("mid-read reset addr", bus.addr, 7'h00);
        chk("mid-read reset busy", bus.busy, 1'b0);
        chk("mid-read reset strobes", {bus.addr_we, bus.dm_we, bus.miso_en, bus.abort_err}, 4'h0);
        @(posedge clk);
        #1;
        reset = 1'b0; bus.cs_n = 1'b0; bus.sclk_pos = 1'b0; bus.sclk_neg = 1'b0;
        @(negedge clk);
        chk("post-reset idle busy", bus.busy, 1'b0);

        // Fresh write after reset: address 0x80 (addr 0x40), data 0x96.
        shift_bits(8'h80, 8, 1'b0, "post addr");
        cyc(0, 0, 0, 0);
        chk("post addr_we", bus.addr_we, 1'b1);
        chk("post sr_q addr", bus.sr_q, 8'h80);
        shift_bits(8'h96, 8, 1'b0, "post data");
        chk("post addr", bus.addr, 7'h40);
        cyc(0, 0, 0, 0);
        chk("post dm_we", bus.dm_we, 1'b1);
        chk("post sr_q data", bus.sr_q, 8'h96);
        cyc(1, 0, 0, 0);
        chk("post done busy", bus.busy, 1'b1);
        cyc(1, 0, 0, 0);
        chk("post idle busy", bus.busy, 1'b0);
        chk("final dm_we count", dm_cnt, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
